// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage -- MEM pipeline stage with a single-outstanding data-memory port.
//
// Loads and stores coming out of EX/MEM become one request on the dmem_*
// port. The stage stalls the front of the pipeline while the access is in
// flight, returns a size-formatted, sign- or zero-extended load result on
// ReadData, and flags illegal (and optionally misaligned) accesses on mem_err.
//
// Access sequence: IDLE (request seen, stall high) -> BUSY (request held until
// dmem_ready, stall high) -> DONE (stall low for one cycle, inputs ignored)
// -> IDLE. With a zero-wait memory that is 2 stall cycles and 3 cycles from
// access to IDLE.
//
// Configuration macro:
//   MISALIGN_TRAP_EN  defined   : misaligned half/word/dword accesses issue no
//                                 request, pulse mem_err and do not stall.
//                     undefined : the address is forced to natural alignment
//                                 and the access proceeds (default build).
//
// Ports:
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   EM_MemRead    in   1   load in MEM stage
//   EM_MemWrite   in   1   store in MEM stage (wins if both are high)
//   EM_Funct3     in   3   size/sign: lb lh lw ld lbu lhu lwu; 111 illegal
//   EM_Result     in  64   effective byte address
//   EM_WriteData  in  64   store data, right-justified
//   ReadData      out 64   registered, formatted load result
//   mem_stall     out  1   combinational stall for PC, IF/ID, ID/EX, EX/MEM
//   mem_err       out  1   registered one-cycle error pulse
//   dmem_req      out  1   registered memory request
//   dmem_we       out  1   registered write enable
//   dmem_addr     out 64   8-byte-aligned word address
//   dmem_wdata    out 64   lane-shifted store data
//   dmem_be       out  8   lane-shifted byte enables
//   dmem_ready    in   1   completion strobe (only honoured in BUSY)
//   dmem_rdata    in  64   64-bit read word, valid with dmem_ready
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        EM_MemRead,
    input  logic        EM_MemWrite,
    input  logic [2:0]  EM_Funct3,
    input  logic [63:0] EM_Result,
    input  logic [63:0] EM_WriteData,
    output logic [63:0] ReadData,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // funct3[1:0] encodes the access size for loads and stores alike.
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Access decode (combinational, from the EX/MEM register)
    // ------------------------------------------------------------------
    logic        access;
    logic        is_store;
    logic        is_load;
    logic        illegal;
    logic        misaligned;
    logic        bad_align;
    logic        start_ok;
    logic        err_now;
    size_t       size;
    logic [2:0]  align_mask;
    logic [2:0]  lane;
    logic [7:0]  be_base;
    logic [7:0]  be_shifted;
    logic [63:0] wdata_shifted;

    // Captured at request time so the load can be formatted when the
    // read word arrives, independent of what EX/MEM holds by then.
    logic [2:0]  ld_lane;
    logic [2:0]  ld_funct3;
    logic        ld_pending;
    logic [63:0] ld_shifted;
    logic [63:0] ld_formatted;

    assign access   = EM_MemRead | EM_MemWrite;
    // A store with MemRead also high is still only a store.
    assign is_store = EM_MemWrite;
    assign is_load  = EM_MemRead & ~EM_MemWrite;
    assign illegal  = (EM_Funct3 == 3'b111);
    assign size     = size_t'(EM_Funct3[1:0]);

    // NOTE: every signal written in an always_comb gets a value before the
    // case, otherwise an unassigned path infers a latch.
    always_comb begin
        align_mask = 3'b111;
        misaligned = 1'b0;
        be_base    = 8'h01;
        case (size)
            SZ_BYTE: begin
                align_mask = 3'b111;
                misaligned = 1'b0;
                be_base    = 8'h01;
            end
            SZ_HALF: begin
                align_mask = 3'b110;
                misaligned = EM_Result[0];
                be_base    = 8'h03;
            end
            SZ_WORD: begin
                align_mask = 3'b100;
                misaligned = |EM_Result[1:0];
                be_base    = 8'h0F;
            end
            SZ_DWORD: begin
                align_mask = 3'b000;
                misaligned = |EM_Result[2:0];
                be_base    = 8'hFF;
            end
            default: begin
                align_mask = 3'b111;
                misaligned = 1'b0;
                be_base    = 8'h01;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign bad_align = misaligned;
`else
    // Misalignment is silently fixed by clearing the low address bits below.
    assign bad_align = 1'b0;
`endif

    // Clearing the sub-size bits is a no-op for aligned addresses, so the
    // same lane serves both builds.
    assign lane          = EM_Result[2:0] & align_mask;
    assign be_shifted    = be_base << lane;
    assign wdata_shifted = EM_WriteData << {lane, 3'b000};

    assign start_ok = access & ~illegal & ~bad_align;
    assign err_now  = access & (illegal | bad_align);

    // ------------------------------------------------------------------
    // Load formatting: bring the addressed lane down to bit 0, then
    // extend according to the captured funct3.
    // ------------------------------------------------------------------
    assign ld_shifted = dmem_rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_formatted = 64'd0;
        case (ld_funct3)
            3'b000:  ld_formatted = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
            3'b001:  ld_formatted = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010:  ld_formatted = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            3'b011:  ld_formatted = ld_shifted;
            3'b100:  ld_formatted = {56'd0, ld_shifted[7:0]};
            3'b101:  ld_formatted = {48'd0, ld_shifted[15:0]};
            3'b110:  ld_formatted = {32'd0, ld_shifted[31:0]};
            default: ld_formatted = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and the combinational stall
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx  = BUSY;
                    mem_stall = 1'b1;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem_ready) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // EX/MEM still shows the finished access; let it drain.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Request, response and error registers
    // ------------------------------------------------------------------
    // NOTE: the request payload registers are reset along with the control
    // bits so the port shows all-zero out of reset, not stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadData   <= 64'd0;
            mem_err    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_wdata <= 64'd0;
            dmem_be    <= 8'd0;
            ld_lane    <= 3'd0;
            ld_funct3  <= 3'd0;
            ld_pending <= 1'b0;
        end else begin
            // Errors are only raised for accesses seen in IDLE, so the
            // pulse is exactly one cycle wide.
            mem_err <= (state == IDLE) && err_now;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {EM_Result[63:3], 3'b000};
                        dmem_wdata <= wdata_shifted;
                        dmem_be    <= be_shifted;
                        ld_lane    <= lane;
                        ld_funct3  <= EM_Funct3;
                        ld_pending <= is_load;
                    end else if (access && illegal) begin
                        ReadData <= 64'd0;
                    end
                end
                BUSY: begin
                    // Address, data and enables stay untouched while waiting.
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (ld_pending) begin
                            ReadData <= ld_formatted;
                        end
                    end
                end
                default: begin
                    // DONE: inputs and dmem_ready are ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage -- self-checking bench for mem_stage.
//
// A transaction-level model computes, from address/size arithmetic, what each
// access must produce (request fields, stall length, load result, error
// pulse) and publishes per-cycle expectations; one compare process checks the
// DUT against them on every falling edge. Directed accesses pin the model with
// literal values, then a randomized run exercises sizes, lanes, wait states,
// illegal encodings and stray dmem_ready strobes.
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EM_MemRead;
    logic        EM_MemWrite;
    logic [2:0]  EM_Funct3;
    logic [63:0] EM_Result;
    logic [63:0] EM_WriteData;
    logic [63:0] ReadData;
    logic        mem_stall;
    logic        mem_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .EM_MemRead   (EM_MemRead),
        .EM_MemWrite  (EM_MemWrite),
        .EM_Funct3    (EM_Funct3),
        .EM_Result    (EM_Result),
        .EM_WriteData (EM_WriteData),
        .ReadData     (ReadData),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle expectations published by the model
    // ------------------------------------------------------------------
    bit          chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_we = 1'b0;
    logic [63:0] exp_rd = 64'd0;
    logic [63:0] exp_addr = 64'd0;
    logic [63:0] exp_wdata = 64'd0;
    logic [7:0]  exp_be = 8'd0;

    // Observations used by the literal checks.
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [63:0] seen_addr = 64'd0;
    logic [63:0] seen_wdata = 64'd0;
    logic [7:0]  seen_be = 8'd0;
    logic        seen_we = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 64'(mem_stall), 64'(exp_stall));
            check("req", 64'(dmem_req), 64'(exp_req));
            check("err", 64'(mem_err), 64'(exp_err));
            check("readdata", ReadData, exp_rd);
            if (exp_req) begin
                check("we", 64'(dmem_we), 64'(exp_we));
                check("addr", dmem_addr, exp_addr);
                check("be", 64'(dmem_be), 64'(exp_be));
                check("wdata", dmem_wdata, exp_wdata);
            end
            if (mem_stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                seen_addr  = dmem_addr;
                seen_wdata = dmem_wdata;
                seen_be    = dmem_be;
                seen_we    = dmem_we;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Byte lane actually used: address rounded down to the access size.
    function automatic int eff_lane(input logic [63:0] addr, input logic [2:0] f3);
        int nb;
        nb = size_bytes(f3);
        return (int'(addr[2:0]) / nb) * nb;
    endfunction

    function automatic logic [63:0] fmt_load(input logic [63:0] word, input logic [2:0] f3, input int lane);
        int          nb;
        logic [63:0] v;
        logic [63:0] mask;
        nb = size_bytes(f3);
        v  = word >> (8 * lane);
        if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access as EX/MEM presents it: held through IDLE, BUSY and DONE
    // when it stalls, a single cycle otherwise. 'delay' is the number of
    // BUSY cycles before the one carrying dmem_ready. Returns one cycle
    // after the access has left, with registered expectations updated.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] rdat, input int delay);
        bit acc, legal, bad, valid;
        int nb, lane;
        acc   = rd | wr;
        nb    = size_bytes(f3);
        legal = (f3 != 3'b111);
`ifdef MISALIGN_TRAP_EN
        bad   = (addr % 64'(nb)) != 64'd0;
`else
        bad   = 1'b0;
`endif
        valid = acc && legal && !bad;
        lane  = eff_lane(addr, f3);

        EM_MemRead   = rd;
        EM_MemWrite  = wr;
        EM_Funct3    = f3;
        EM_Result    = addr;
        EM_WriteData = wd;
        dmem_ready   = 1'($urandom_range(0, 1));
        dmem_rdata   = rand64();
        exp_stall    = valid;
        next_cycle();

        exp_err = acc && (!legal || bad);
        if (acc && !legal) exp_rd = 64'd0;
        if (!valid) return;

        exp_req   = 1'b1;
        exp_we    = wr;
        exp_addr  = {addr[63:3], 3'b000};
        exp_be    = 8'(((1 << nb) - 1) << lane);
        exp_wdata = wd << (8 * lane);
        for (int i = 0; i <= delay; i++) begin
            exp_stall  = 1'b1;
            dmem_ready = (i == delay);
            dmem_rdata = (i == delay) ? rdat : rand64();
            next_cycle();
        end
        exp_req = 1'b0;
        if (rd && !wr) exp_rd = fmt_load(rdat, f3, lane);

        exp_stall  = 1'b0;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = rand64();
        next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] f3;
        bit         rd, wr;
        reset        = 1'b1;
        EM_MemRead   = 1'b0;
        EM_MemWrite  = 1'b0;
        EM_Funct3    = 3'b000;
        EM_Result    = 64'd0;
        EM_WriteData = 64'd0;
        dmem_ready   = 1'b0;
        dmem_rdata   = 64'd0;

        // Reset state.
        #12;
        check("rst_readdata", ReadData, 64'd0);
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_we", 64'(dmem_we), 64'd0);
        check("rst_be", 64'(dmem_be), 64'd0);
        check("rst_addr", dmem_addr, 64'd0);
        check("rst_wdata", dmem_wdata, 64'd0);
        check("rst_err", 64'(mem_err), 64'd0);
        check("rst_stall", 64'(mem_stall), 64'd0);
        next_cycle();
        reset  = 1'b0;
        chk_en = 1'b1;
        do_access(0, 0, 3'b000, 64'd0, 64'd0, 64'd0, 0);

        // ld, zero-wait memory.
        stall_cnt = 0;
        do_access(1, 0, 3'b011, 64'h1000, 64'd0, 64'h1122334455667788, 0);
        check("ld_stall_cycles", 64'(stall_cnt), 64'd2);
        check("ld_readdata", ReadData, 64'h1122334455667788);
        check("ld_addr", seen_addr, 64'h1000);

        // lb / lbu from lane 3.
        do_access(1, 0, 3'b000, 64'h1003, 64'd0, 64'h00000000F0000000, 0);
        check("lb_readdata", ReadData, 64'hFFFFFFFFFFFFFFF0);
        do_access(1, 0, 3'b100, 64'h1003, 64'd0, 64'h00000000F0000000, 1);
        check("lbu_readdata", ReadData, 64'h00000000000000F0);

        // sh to lane 6; ReadData must hold across the store.
        do_access(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 0);
        check("sh_be", 64'(seen_be), 64'hC0);
        check("sh_wdata", seen_wdata, 64'hABCD000000000000);
        check("sh_we", 64'(seen_we), 64'd1);
        check("sh_readdata_held", ReadData, 64'h00000000000000F0);

        // lw with ready on the fourth BUSY cycle.
        stall_cnt = 0;
        req_cnt   = 0;
        do_access(1, 0, 3'b010, 64'h3000, 64'd0, 64'h00000000_80000001, 3);
        check("lw_wait_stall_cycles", 64'(stall_cnt), 64'd5);
        check("lw_wait_req_cycles", 64'(req_cnt), 64'd4);
        check("lw_wait_addr", seen_addr, 64'h3000);
        check("lw_wait_readdata", ReadData, 64'hFFFFFFFF80000001);

        // Misaligned lw.
        stall_cnt = 0;
        req_cnt   = 0;
        do_access(1, 0, 3'b010, 64'h3002, 64'd0, 64'hDEADBEEF12345678, 0);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_err", 64'(mem_err), 64'd1);
        check("lw_mis_req_cycles", 64'(req_cnt), 64'd0);
        check("lw_mis_stall_cycles", 64'(stall_cnt), 64'd0);
`else
        check("lw_mis_addr", seen_addr, 64'h3000);
        check("lw_mis_readdata", ReadData, 64'h0000000012345678);
        check("lw_mis_stall_cycles", 64'(stall_cnt), 64'd2);
`endif
        do_access(0, 0, 3'b000, 64'd0, 64'd0, 64'd0, 0);

        // Illegal funct3: one-cycle error, ReadData cleared, no stall.
        do_access(0, 0, 3'b000, 64'd0, 64'd0, 64'd0, 0);
        do_access(1, 0, 3'b011, 64'h4000, 64'd0, 64'h0123456789ABCDEF, 0);
        stall_cnt = 0;
        do_access(1, 0, 3'b111, 64'h4000, 64'd0, 64'd0, 0);
        check("illegal_err", 64'(mem_err), 64'd1);
        check("illegal_readdata", ReadData, 64'd0);
        check("illegal_stall_cycles", 64'(stall_cnt), 64'd0);
        do_access(0, 0, 3'b000, 64'd0, 64'd0, 64'd0, 0);

        // Reset in BUSY, then a late dmem_ready.
        do_access(1, 0, 3'b011, 64'h5000, 64'd0, 64'h55AA55AA55AA55AA, 0);
        EM_MemRead = 1'b1;
        EM_Funct3  = 3'b011;
        EM_Result  = 64'h6000;
        dmem_ready = 1'b0;
        exp_stall  = 1'b1;
        next_cycle();
        check("busy_before_reset", 64'(dmem_req), 64'd1);
        chk_en = 1'b0;
        reset  = 1'b1;
        #2;
        check("busy_reset_req", 64'(dmem_req), 64'd0);
        check("busy_reset_readdata", ReadData, 64'd0);
        next_cycle();
        reset       = 1'b0;
        EM_MemRead  = 1'b0;
        dmem_ready  = 1'b1;
        exp_stall   = 1'b0;
        exp_req     = 1'b0;
        exp_err     = 1'b0;
        exp_rd      = 64'd0;
        chk_en      = 1'b1;
        next_cycle();
        // Held load right after: stalls at once, so the FSM is in IDLE.
        EM_MemRead = 1'b1;
        #1;
        check("after_reset_stall", 64'(mem_stall), 64'd1);
        do_access(1, 0, 3'b011, 64'h6000, 64'd0, 64'hCAFEF00DCAFEF00D, 0);
        check("after_reset_readdata", ReadData, 64'hCAFEF00DCAFEF00D);

        // Randomized accesses.
        for (int n = 0; n < 400; n++) begin
            f3 = ($urandom_range(0, 15) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0:       begin rd = 0; wr = 0; end
                1, 2:    begin rd = 1; wr = 0; end
                3, 4:    begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            do_access(rd, wr, f3, rand64(), rand64(), rand64(), int'($urandom_range(0, 4)));
        end
        do_access(0, 0, 3'b000, 64'd0, 64'd0, 64'd0, 0);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 EM_MemRead  input  1  load in MEM stage.
REQ-004 EM_MemWrite  input  1  store in MEM stage.
REQ-005 EM_Funct3  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 illegal.
REQ-006 EM_Result  input  64  effective byte address from the ALU.
REQ-007 EM_WriteData  input  64  store data, right-justified.
REQ-008 ReadData  output  64  registered, size-formatted load result, consumed by MEM/WB.
REQ-009 mem_stall  output  1  combinational; high freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-010 mem_err  output  1  registered one-cycle pulse for an illegal or misaligned access.
REQ-011 dmem_req, dmem_we  output  1 each  registered request and write-enable.
REQ-012 dmem_addr  output  64  8-byte-aligned address (bits [2:0] = 0).
REQ-013 dmem_wdata  output  64; dmem_be  output  8  lane-shifted store data and byte enables.
REQ-014 dmem_ready  input  1; dmem_rdata  input  64  completion strobe and 64-bit read word.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE: a valid access (EM_MemRead or EM_MemWrite, legal, aligned) moves to BUSY next edge, asserting dmem_req with address/data/be registered; mem_stall is high in this cycle.
REQ-017 Both EM_MemRead and EM_MemWrite high is treated as a store only.
REQ-018 BUSY: dmem_req is held with stable address/data/be until dmem_ready = 1; mem_stall stays high.
REQ-019 On dmem_ready in BUSY: dmem_req drops next edge; for loads ReadData captures the formatted word; FSM moves to DONE.
REQ-020 DONE: mem_stall is low for exactly one cycle; inputs are ignored; FSM returns to IDLE.
REQ-021 Minimum latency with zero-wait memory: 2 stall cycles, 3 cycles access-to-IDLE.
REQ-022 Lane = EM_Result[2:0]; loads shift right by 8*lane, then sign- or zero-extend to 64 by funct3.
REQ-023 Stores shift data left by 8*lane; be = 0x01/0x03/0x0F/0xFF shifted by lane.
REQ-024 Funct3 111: no request; mem_err pulses; ReadData is 0; no stall.
REQ-025 ReadData holds its value across store and idle cycles.
REQ-026 dmem_ready in IDLE or DONE is ignored.

Reset
REQ-027 Reset forces IDLE with ReadData = 0 and dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_err = 0; mem_stall = 0.
REQ-028 Reset during BUSY abandons the access; a late dmem_ready is ignored per REQ-026.

Configuration
REQ-029 MISALIGN_TRAP_EN defined: misaligned accesses (half addr[0] != 0, word addr[1:0] != 0, dword addr[2:0] != 0) issue no request, pulse mem_err, and do not stall.
REQ-030 MISALIGN_TRAP_EN undefined: the address is forced to natural alignment (low bits cleared per size) and the access proceeds; mem_err pulses only for funct3 111.

Verification
REQ-031 ld, addr 0x1000, dmem_rdata 0x1122334455667788, ready at first BUSY cycle -> stall 2 cycles, ReadData 0x1122334455667788, dmem_addr 0x1000.
REQ-032 lb, addr 0x1003, rdata 0x00000000_F0000000 -> ReadData 0xFFFFFFFFFFFFFFF0; lbu -> 0x00000000000000F0.
REQ-033 sh, addr 0x2006, data 0xABCD -> dmem_be 0xC0, dmem_wdata 0xABCD000000000000, dmem_we 1.
REQ-034 lw, addr 0x3000, ready delayed 4 cycles -> dmem_req and address stable throughout; stall 5 cycles.
REQ-035 lw, addr 0x3002 -> with MISALIGN_TRAP_EN: no dmem_req, mem_err one cycle; without it: dmem_addr 0x3000 and lane 0 returned.
REQ-036 reset asserted in BUSY, then dmem_ready -> IDLE, dmem_req 0, ReadData 0, no DONE cycle.
